rsa_const_gen: RTL

Montgomery constant generator placed directly upstream of the RSA unit's `Const` input. Given the modulus P, it computes Const = 2^(2·WIDTH) mod P by repeated modular doubling. Software then only programs P, E and M. The block is started by the enable controller before the RSA unit is released. Its result replaces the SPI-written constant register as the source of `Const`.

---
 rtl/rsa_const_gen.sv | 110 +++++++++++
 1 files changed

// File: rtl/rsa_const_gen.sv
// rtl/rsa_const_gen.sv - Montgomery constant Const = 2^(2*WIDTH) mod P by repeated modular doubling
// Optional modulus check (even P or P < 3 flagged on err) enabled by defining RSA_CONST_GEN_CHECK_EN.
module rsa_const_gen #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] P,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] Const
);

  localparam int            CW   = $clog2(2 * WIDTH);
  localparam logic [CW-1:0] LAST = CW'(2 * WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] p_q, p_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] const_q, const_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [WIDTH:0]   t, t_sub;
  logic             bad_p;
  logic             wr;

  // x stays below p_q, so only the doubled value needs the extra bit
  assign t     = {x_q, 1'b0};
  assign t_sub = t - {1'b0, p_q};

`ifdef RSA_CONST_GEN_CHECK_EN
  assign bad_p = !P[0] || (P < WIDTH'(3));
`else
  assign bad_p = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    x_d     = x_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    done    = 1'b0;
    if (ena) begin
      case (state_q)
        IDLE: begin
          if (start && !abort) begin
            p_d     = P;
            x_d     = '0;
            x_d[0]  = (P > WIDTH'(1));
            cnt_d   = '0;
            err_d   = bad_p;
            state_d = bad_p ? DONE : CALC;
          end
        end
        CALC: begin
          if (abort) begin
            state_d = IDLE;
          end else begin
            x_d   = (t >= {1'b0, p_q}) ? t_sub[WIDTH-1:0] : t[WIDTH-1:0];
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST) state_d = DONE;
          end
        end
        DONE: begin
          state_d = IDLE;
          done    = !abort;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // The new result is shown in the DONE cycle itself; an invalid modulus never overwrites it
  assign wr      = done && !err_q;
  assign const_d = wr ? x_q : const_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      p_q     <= '0;
      x_q     <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      const_q <= '0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      x_q     <= x_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      const_q <= const_d;
    end
  end

  assign busy  = (state_q != IDLE);
  assign err   = err_q;
  assign Const = wr ? x_q : const_q;

endmodule
